// File: rtl/rca_div_if.sv
// Divider request/result bundle: operands and start handshake in, quotient/remainder out.
// Latency: none (wires only).
// Backpressure: in_div_ready from the divider gates acceptance of in_div_start.
//
// Ports (signals):
//   in_div_start / in_div_ready         request handshake
//   in_div_dividend [2W], in_div_divisor [W]  operands
//   out_div_quotient [2W], out_div_remainder [W], out_div_valid, out_div_by_zero  results
interface rca_div_if #(
   parameter int DATA_WIDTH = 32
);
   logic                      in_div_start;
   logic                      in_div_ready;
   logic [2*DATA_WIDTH-1:0]   in_div_dividend;
   logic [DATA_WIDTH-1:0]     in_div_divisor;
   logic [2*DATA_WIDTH-1:0]   out_div_quotient;
   logic [DATA_WIDTH-1:0]     out_div_remainder;
   logic                      out_div_valid;
   logic                      out_div_by_zero;

   // Requester side.
   modport master (
      output in_div_start, in_div_dividend, in_div_divisor,
      input  in_div_ready, out_div_quotient, out_div_remainder, out_div_valid, out_div_by_zero
   );

   // Divider side.
   modport slave (
      input  in_div_start, in_div_dividend, in_div_divisor,
      output in_div_ready, out_div_quotient, out_div_remainder, out_div_valid, out_div_by_zero
   );
endinterface

// File: rtl/rca_div.sv
// Sequential radix-2 restoring divider: 2W-bit dividend / W-bit divisor -> 2W-bit quotient, W-bit remainder.
// Latency: valid in the cycle after edge k+2W+1 for a start accepted at edge k (k+1 for divisor 0).
// Backpressure: in_div_ready only in IDLE; starts while busy are dropped; enable=0 freezes everything.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset (wins over enable)
//   enable  clock enable for all state, including the valid pulse
//   div     rca_div_if.slave: start/ready handshake, operands, results, valid, by_zero
module rca_div #(
   parameter int DATA_WIDTH = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      enable,
   rca_div_if.slave  div
);

   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(2 * W) + 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(2 * W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   // dvd_q starts as the dividend and fills with quotient bits from the bottom
   // as the dividend bits are shifted out of the top.
   logic [2*W-1:0]   dvd_q;
   logic [W-1:0]     dsr_q;
   logic [W-1:0]     rem_q;
   logic [CNT_W-1:0] cnt_q;
   logic             dz_q;

   logic [2*W-1:0]   quo_q;
   logic [W-1:0]     rem_out_q;
   logic             vld_q;
   logic             bz_q;

   logic [W:0]       trial;
   logic [W-1:0]     diff;
   logic             qbit;

   // Trial remainder is W+1 bits so a full-scale partial remainder shifted
   // left never loses its top bit. When the subtraction succeeds the result
   // is below the divisor, so the low W bits of the difference are exact.
   assign trial = {rem_q, dvd_q[2*W-1]};
   assign qbit  = (trial >= {1'b0, dsr_q});
   assign diff  = trial[W-1:0] - dsr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else if (enable) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (div.in_div_start) begin
               state_d = (div.in_div_divisor == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (cnt_q == LAST_ITER) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dvd_q     <= '0;
         dsr_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         dz_q      <= 1'b0;
         quo_q     <= '0;
         rem_out_q <= '0;
         vld_q     <= 1'b0;
         bz_q      <= 1'b0;
      end else if (enable) begin
         // Valid is a single enabled-cycle pulse; with enable low it simply holds.
         vld_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (div.in_div_start) begin
                  dvd_q <= div.in_div_dividend;
                  dsr_q <= div.in_div_divisor;
                  rem_q <= '0;
                  cnt_q <= '0;
                  dz_q  <= (div.in_div_divisor == '0);
               end
            end
            RUN: begin
               rem_q <= qbit ? diff : trial[W-1:0];
               dvd_q <= {dvd_q[2*W-2:0], qbit};
               cnt_q <= cnt_q + CNT_W'(1);
            end
            DONE: begin
               vld_q <= 1'b1;
               bz_q  <= dz_q;
               // For a zero divisor no iterations ran, so dvd_q still holds the dividend.
               quo_q     <= dz_q ? '1 : dvd_q;
               rem_out_q <= dz_q ? dvd_q[W-1:0] : rem_q;
            end
            default: ;
         endcase
      end
   end

   assign div.in_div_ready      = (state_q == IDLE);
   assign div.out_div_quotient  = quo_q;
   assign div.out_div_remainder = rem_out_q;
   assign div.out_div_valid     = vld_q;
   assign div.out_div_by_zero   = bz_q;

endmodule

// File: tb/tb_rca_div.sv
// Self-checking bench for rca_div (W=32): directed boundaries plus random ops against an arithmetic model.
// Latency: checks enabled-edge count from acceptance to valid.
// Backpressure: exercises enable toggling and starts issued while busy.
module tb_rca_div;

   localparam int W = 32;

   logic clk;
   logic rst_n;
   logic enable;

   int checks = 0;
   int errors = 0;

   rca_div_if #(.DATA_WIDTH(W)) bus ();

   rca_div #(.DATA_WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .div    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full operation. Expected results come from plain 64-bit arithmetic.
   task automatic run_op(input logic [63:0] dvd, input logic [31:0] dsr,
                         input bit tog, input bit busy_start, input string tag);
      logic [63:0] eq;
      logic [31:0] er;
      logic        ez;
      int          exp_lat;
      int          en_edges;
      int          all_edges;
      int          extra;
      bit          got;

      if (dsr == 32'd0) begin
         eq = 64'hFFFF_FFFF_FFFF_FFFF;
         er = dvd[31:0];
         ez = 1'b1;
         exp_lat = 1;
      end else begin
         eq = dvd / {32'd0, dsr};
         er = 32'(dvd % {32'd0, dsr});
         ez = 1'b0;
         exp_lat = 2 * W + 1;
      end

      @(negedge clk);
      enable = 1'b1;
      chk({tag, ".ready_before"}, 64'(bus.in_div_ready), 64'd1);
      bus.in_div_start    = 1'b1;
      bus.in_div_dividend = dvd;
      bus.in_div_divisor  = dsr;
      @(posedge clk);
      #1;
      // Operands may change after acceptance; scramble them.
      bus.in_div_start    = 1'b0;
      bus.in_div_dividend = {$urandom, $urandom};
      bus.in_div_divisor  = $urandom;

      en_edges  = 0;
      all_edges = 0;
      got       = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (bus.out_div_valid === 1'b1) begin
            got = 1'b1;
         end else begin
            if (tog) enable = ~enable;
            bus.in_div_start = busy_start && (i == 3);
            @(posedge clk);
            all_edges++;
            if (enable) en_edges++;
         end
      end
      bus.in_div_start = 1'b0;

      chk({tag, ".valid_seen"}, 64'(got), 64'd1);
      chk({tag, ".latency"}, 64'(en_edges), 64'(exp_lat));
      if (tog) chk({tag, ".slow_latency"}, 64'(all_edges >= 2 * exp_lat - 1), 64'd1);
      chk({tag, ".quotient"}, bus.out_div_quotient, eq);
      chk({tag, ".remainder"}, 64'(bus.out_div_remainder), 64'(er));
      chk({tag, ".by_zero"}, 64'(bus.out_div_by_zero), 64'(ez));

      // Valid stretches while enable is low, then drops after one enabled edge.
      enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".valid_stretch"}, 64'(bus.out_div_valid), 64'd1);
      enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".valid_drop"}, 64'(bus.out_div_valid), 64'd0);
      chk({tag, ".ready_after"}, 64'(bus.in_div_ready), 64'd1);
      chk({tag, ".q_hold"}, bus.out_div_quotient, eq);

      if (busy_start) begin
         extra = 0;
         for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.out_div_valid === 1'b1) extra++;
         end
         chk({tag, ".no_queued_op"}, 64'(extra), 64'd0);
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] d;
      int          seen;

      rst_n               = 1'b0;
      enable              = 1'b1;
      bus.in_div_start    = 1'b0;
      bus.in_div_dividend = '0;
      bus.in_div_divisor  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset.ready", 64'(bus.in_div_ready), 64'd1);
      chk("reset.valid", 64'(bus.out_div_valid), 64'd0);
      chk("reset.q", bus.out_div_quotient, 64'd0);
      chk("reset.r", 64'(bus.out_div_remainder), 64'd0);
      chk("reset.bz", 64'(bus.out_div_by_zero), 64'd0);
      rst_n = 1'b1;

      // Basic and zero-divisor cases.
      run_op(64'd100, 32'd7, 1'b0, 1'b0, "t2_basic");
      run_op(64'h1234_5678_9ABC_DEF0, 32'd0, 1'b0, 1'b0, "t4_zero");

      // Reset mid-op: by_zero and results are nonzero before this.
      @(negedge clk);
      bus.in_div_start    = 1'b1;
      bus.in_div_dividend = 64'd100;
      bus.in_div_divisor  = 32'd7;
      @(posedge clk);
      #1;
      bus.in_div_start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("t1.ready", 64'(bus.in_div_ready), 64'd1);
      chk("t1.valid", 64'(bus.out_div_valid), 64'd0);
      chk("t1.q", bus.out_div_quotient, 64'd0);
      chk("t1.r", 64'(bus.out_div_remainder), 64'd0);
      chk("t1.bz", 64'(bus.out_div_by_zero), 64'd0);
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (bus.out_div_valid === 1'b1) seen++;
      end
      chk("t1.no_valid", 64'(seen), 64'd0);

      // Extremes and boundaries.
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 1'b0, 1'b0, "t5_div1");
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "t5_divmax");
      run_op(64'd0, 32'd13, 1'b0, 1'b0, "b_dvd0");
      run_op(64'd5, 32'd9, 1'b0, 1'b0, "b_small");
      run_op(64'hFFFF_FFFF_FFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b0, "b_fullrem");
      run_op(64'd0, 32'd0, 1'b0, 1'b0, "b_zero_zero");

      // Inverse of multiplication.
      for (int n = 0; n < 100; n++) begin
         a = $urandom;
         b = $urandom;
         if (n % 4 == 1) b = b >> $urandom_range(31, 16);
         if (b == 32'd0) b = 32'd1;
         d = {32'd0, a} * {32'd0, b};
         run_op(d, b, 1'b0, 1'b0, "t3_inverse");
      end

      // Random dividend/divisor.
      for (int n = 0; n < 20; n++) begin
         d = {$urandom, $urandom};
         b = $urandom >> $urandom_range(31, 0);
         run_op(d, b, 1'b0, 1'b0, "rand");
      end

      // Enable toggling and a start while busy.
      run_op(64'd100, 32'd7, 1'b1, 1'b1, "t6_toggle_busy");
      run_op({$urandom, $urandom}, $urandom | 32'd1, 1'b1, 1'b0, "t6_toggle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
